// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out serializer.
package piso_pkg;

  // Top-level FSM: IDLE holds no word in flight, SHIFT presents bits from sreg.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_t;

  // Width of the per-word bit counter (counts DATA_W-1 down to 0).
  function automatic int unsigned cnt_w(input int unsigned data_w);
    return $clog2(data_w);
  endfunction

endpackage

// File: rtl/piso_shift_stage.sv
// Shift register, bit counter and serial output muxing for piso_serializer.
// The parent decides when to load a fresh word and when to advance by one bit.
module piso_shift_stage
  import piso_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              active_i,     // parent FSM is in SHIFT
  input  logic              load_i,       // load load_data_i, restart the count
  input  logic [DATA_W-1:0] load_data_i,
  input  logic              shift_i,      // advance one bit (ignored when load_i)
  output logic              serial_o,
  output logic              last_o,
  output logic              cnt_zero_o
);

  localparam int unsigned          CntW   = cnt_w(DATA_W);
  localparam logic [CntW-1:0]      CntMax = CntW'(DATA_W - 1);

  logic [DATA_W-1:0] sreg_q;
  logic [DATA_W-1:0] sreg_shifted;
  logic [CntW-1:0]   cnt_q;
  logic              out_bit;

  // Move one place toward the output end, zero-filling the far end.
  if (LSB_FIRST) begin : g_lsb
    assign sreg_shifted = {1'b0, sreg_q[DATA_W-1:1]};
    assign out_bit      = sreg_q[0];
  end else begin : g_msb
    assign sreg_shifted = {sreg_q[DATA_W-2:0], 1'b0};
    assign out_bit      = sreg_q[DATA_W-1];
  end

  // Shift register and bit counter; a load always wins over a shift.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sreg_q <= '0;
      cnt_q  <= '0;
    end else if (load_i) begin
      sreg_q <= load_data_i;
      cnt_q  <= CntMax;
    end else if (shift_i) begin
      sreg_q <= sreg_shifted;
      cnt_q  <= cnt_q - 1'b1;
    end
  end

  // Outputs are forced low outside SHIFT, since sreg still holds the
  // final bit of the previous word after returning to IDLE.
  always_comb begin
    cnt_zero_o = (cnt_q == '0);
    serial_o   = active_i & out_bit;
    last_o     = active_i & cnt_zero_o;
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out converter with a valid/ready load port, a one-word
// holding buffer and a stallable serial output. Back-to-back words stream
// without a gap: the next word moves into the shifter on the same edge the
// last bit of the current word is consumed.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid_i,
  output logic              load_ready_o,
  input  logic [DATA_W-1:0] parallel_i,
  output logic              serial_o,
  output logic              valid_o,
  output logic              last_o,
  input  logic              serial_ready_i,
  output logic              empty_o
);

  piso_state_t       state_q;
  logic [DATA_W-1:0] hold_q;
  logic              hold_full_q;

  logic              active;
  logic              load_hs;
  logic              bit_hs;
  logic              cnt_zero;
  logic              word_done;

  logic              stage_load;
  logic              stage_shift;
  logic [DATA_W-1:0] stage_data;

  // Handshakes and status derived from registered state only.
  always_comb begin
    active       = (state_q == SHIFT);
    load_ready_o = !hold_full_q;
    load_hs      = load_valid_i && !hold_full_q;
    bit_hs       = active && serial_ready_i;
    word_done    = bit_hs && cnt_zero;
    valid_o      = active;
    empty_o      = (state_q == IDLE) && !hold_full_q;
  end

  // Shifter control: pick a new word source at word end, else advance a bit.
  always_comb begin
    stage_load  = 1'b0;
    stage_shift = 1'b0;
    stage_data  = parallel_i;
    case (state_q)
      IDLE: begin
        stage_load = load_hs;
      end
      SHIFT: begin
        if (bit_hs) begin
          if (!cnt_zero) begin
            stage_shift = 1'b1;
          end else if (hold_full_q) begin
            // Buffered word takes precedence so acceptance order is kept.
            stage_load = 1'b1;
            stage_data = hold_q;
          end else if (load_hs) begin
            stage_load = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // FSM and holding buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // Hold is empty here, so the word goes straight to the shifter.
          if (load_hs) begin
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (word_done && !hold_full_q && !load_hs) begin
            state_q <= IDLE;
          end
          if (word_done && hold_full_q) begin
            hold_full_q <= 1'b0;
          end else if (load_hs && !word_done) begin
            // Word arrives mid-stream: park it until the shifter frees up.
            hold_q      <= parallel_i;
            hold_full_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  piso_shift_stage #(
    .DATA_W    (DATA_W),
    .LSB_FIRST (LSB_FIRST)
  ) u_shift_stage (
    .clk         (clk),
    .reset       (reset),
    .active_i    (active),
    .load_i      (stage_load),
    .load_data_i (stage_data),
    .shift_i     (stage_shift),
    .serial_o    (serial_o),
    .last_o      (last_o),
    .cnt_zero_o  (cnt_zero)
  );

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: an LSB-first and an MSB-first instance share
// one stimulus stream. A word-level model queues the expected bit sequence
// for each accepted word; a monitor on the falling edge compares every cycle.
module tb_piso_serializer;

  localparam int unsigned W = 8;

  logic         clk;
  logic         reset;
  logic         load_valid_i;
  logic [W-1:0] parallel_i;
  logic         serial_ready_i;

  logic ready_l, serial_l, valid_l, last_l, empty_l;
  logic ready_m, serial_m, valid_m, last_m, empty_m;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: words in flight plus per-bit expectations.
  bit exp_l[$];
  bit exp_m[$];
  bit exp_last[$];
  int nwords = 0;

  piso_serializer #(.DATA_W(W), .LSB_FIRST(1'b1)) u_dut_lsb (
    .clk            (clk),
    .reset          (reset),
    .load_valid_i   (load_valid_i),
    .load_ready_o   (ready_l),
    .parallel_i     (parallel_i),
    .serial_o       (serial_l),
    .valid_o        (valid_l),
    .last_o         (last_l),
    .serial_ready_i (serial_ready_i),
    .empty_o        (empty_l)
  );

  piso_serializer #(.DATA_W(W), .LSB_FIRST(1'b0)) u_dut_msb (
    .clk            (clk),
    .reset          (reset),
    .load_valid_i   (load_valid_i),
    .load_ready_o   (ready_m),
    .parallel_i     (parallel_i),
    .serial_o       (serial_m),
    .valid_o        (valid_m),
    .last_o         (last_m),
    .serial_ready_i (serial_ready_i),
    .empty_o        (empty_m)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor and model: compare what is presented now, then advance the
  // model for the upcoming rising edge.
  always @(negedge clk) begin
    bit accept;
    bit was_last;
    bit unused_b;
    if (reset) begin
      exp_l.delete();
      exp_m.delete();
      exp_last.delete();
      nwords = 0;
    end else begin
      check("valid_l", valid_l, nwords > 0);
      check("valid_m", valid_m, nwords > 0);
      check("ready_l", ready_l, nwords < 2);
      check("ready_m", ready_m, nwords < 2);
      check("empty_l", empty_l, nwords == 0);
      check("empty_m", empty_m, nwords == 0);
      if (nwords > 0) begin
        check("serial_l", serial_l, exp_l[0]);
        check("serial_m", serial_m, exp_m[0]);
        check("last_l", last_l, exp_last[0]);
        check("last_m", last_m, exp_last[0]);
      end else begin
        check("serial_l_idle", serial_l, 0);
        check("serial_m_idle", serial_m, 0);
        check("last_l_idle", last_l, 0);
        check("last_m_idle", last_m, 0);
      end
      // Room exists while fewer than two words are in flight.
      accept = load_valid_i && (nwords < 2);
      if (nwords > 0 && serial_ready_i) begin
        was_last = exp_last.pop_front();
        unused_b = exp_l.pop_front();
        unused_b = exp_m.pop_front();
        if (was_last) nwords--;
      end
      if (accept) begin
        for (int i = 0; i < W; i++) begin
          exp_l.push_back(parallel_i[i]);
          exp_m.push_back(parallel_i[W-1-i]);
          exp_last.push_back(i == W - 1);
        end
        nwords++;
      end
    end
  end

  // Apply one cycle of inputs, then step to just after the next rising edge.
  task automatic drive(input logic lv, input logic [W-1:0] d, input logic sr);
    load_valid_i   = lv;
    parallel_i     = d;
    serial_ready_i = sr;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_empty(input string name);
    int cyc;
    cyc            = 0;
    load_valid_i   = 1'b0;
    serial_ready_i = 1'b1;
    while (!(empty_l && empty_m) && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check(name, empty_l && empty_m, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready_l"}, ready_l, 1);
    check({tag, "_ready_m"}, ready_m, 1);
    check({tag, "_valid_l"}, valid_l, 0);
    check({tag, "_valid_m"}, valid_m, 0);
    check({tag, "_serial_l"}, serial_l, 0);
    check({tag, "_serial_m"}, serial_m, 0);
    check({tag, "_last_l"}, last_l, 0);
    check({tag, "_last_m"}, last_m, 0);
    check({tag, "_empty_l"}, empty_l, 1);
    check({tag, "_empty_m"}, empty_m, 1);
  endtask

  initial begin
    reset          = 1'b1;
    load_valid_i   = 1'b0;
    parallel_i     = '0;
    serial_ready_i = 1'b0;
    #2;
    check_reset_outputs("por");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Single word, continuous consumption.
    drive(1'b1, 8'hA5, 1'b1);
    wait_empty("single_a5_drain");

    // Two words back to back: second lands in hold.
    drive(1'b1, 8'hA5, 1'b1);
    drive(1'b1, 8'h3C, 1'b1);
    check("hold_full_ready_l", ready_l, 0);
    wait_empty("pair_drain");

    // Stall after bit 2 for three cycles.
    drive(1'b1, 8'hF0, 1'b1);
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b1);
    repeat (3) drive(1'b0, 8'h00, 1'b0);
    wait_empty("stall_drain");

    // New word offered on the cycle of last_o with hold empty.
    drive(1'b1, 8'h5A, 1'b1);
    repeat (7) drive(1'b0, 8'h00, 1'b1);
    check("last_before_reload", last_l, 1);
    drive(1'b1, 8'hC3, 1'b1);
    check("reload_no_bubble", valid_l, 1);
    wait_empty("reload_drain");

    // Reset mid-word with hold full.
    drive(1'b1, 8'hA5, 1'b1);
    drive(1'b1, 8'h3C, 1'b1);
    repeat (3) drive(1'b0, 8'h00, 1'b1);
    check("pre_reset_hold_full", ready_l, 0);
    reset = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    load_valid_i = 1'b1;
    parallel_i   = 8'h77;
    @(posedge clk);
    #1;
    check_reset_outputs("rst_ignores_load");
    load_valid_i = 1'b0;
    reset        = 1'b0;
    drive(1'b0, 8'h00, 1'b1);
    check("post_reset_empty", empty_l && empty_m, 1);

    // Randomised traffic.
    for (int i = 0; i < 2000; i++) begin
      drive($urandom_range(0, 2) != 0, W'($urandom), $urandom_range(0, 3) != 0);
    end
    wait_empty("random_drain");
    drive(1'b0, 8'h00, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parametrised parallel-in/serial-out converter with a valid/ready load port, a one-word holding buffer, and a stallable serial output. It takes DATA_W-bit words from an upstream producer and emits them one bit per accepted cycle, LSB- or MSB-first. Back-to-back words stream with no gap between them. It sits between a word-oriented datapath and a bit-serial link, and generalises the fixed 4-bit serializer.

## Interface
- DATA_W, default 8: word width in bits; legal range 2 to 64.
- LSB_FIRST, default 1: 1 sends bit 0 first; 0 sends bit DATA_W-1 first.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  reset, asynchronous, active-high; clock clk.
- load_valid_i  in  1  upstream word present on parallel_i.
- load_ready_o  out  1  block can accept a word this cycle.
- parallel_i  in  DATA_W  word to serialise; sampled only on handshake.
- serial_o  out  1  current serial bit.
- valid_o  out  1  serial_o carries a valid bit.
- last_o  out  1  current bit is the final bit of its word.
- serial_ready_i  in  1  downstream consumes the current bit this cycle.
- empty_o  out  1  no word is in the shifter or the holding buffer.

## Operation
- Storage:
  - shift register sreg[DATA_W-1:0]
  - bit counter cnt, width $clog2(DATA_W)
  - holding register hold[DATA_W-1:0] with flag hold_full
- States:
  - IDLE: no word in flight.
  - SHIFT: sreg is presenting bits.
- Handshake definitions:
  - Load handshake: load_valid_i && load_ready_o. load_ready_o = !hold_full.
  - Bit handshake: valid_o && serial_ready_i.
- Outputs:
  - valid_o = (state == SHIFT).
  - serial_o = sreg[0] when LSB_FIRST=1, else sreg[DATA_W-1]. Forced to 0 in IDLE.
  - last_o = valid_o && (cnt == 0).
  - empty_o = (state == IDLE) && !hold_full.
- IDLE with load handshake: sreg <= parallel_i, cnt <= DATA_W-1, go to SHIFT. hold is untouched.
- SHIFT, bit handshake, cnt != 0: sreg shifts one place toward the output end, zero-filled. cnt decrements.
- SHIFT, bit handshake, cnt == 0 (word finished). Priority order:
  1. hold_full: sreg <= hold, hold_full <= 0, cnt <= DATA_W-1, stay in SHIFT.
  2. Otherwise, load handshake in the same cycle: sreg <= parallel_i, cnt <= DATA_W-1, stay in SHIFT.
  3. Otherwise: go to IDLE.
- SHIFT with a load handshake not consumed by rule 2: hold <= parallel_i, hold_full <= 1.
- No bit handshake (serial_ready_i=0 while valid_o=1): sreg, cnt, serial_o and last_o hold their values. A load may still fill hold.
- A word is never dropped or duplicated. Words leave in acceptance order.

## Timing
- Reset values:
  - load_ready_o=1, valid_o=0, serial_o=0, last_o=0, empty_o=1
  - state=IDLE, sreg=0, hold=0, hold_full=0, cnt=0
- Latency: a word accepted at edge N from IDLE shows its first bit in the cycle after edge N.
- With serial_ready_i held at 1, a word occupies exactly DATA_W cycles of valid_o.
- Back-to-back words produce a continuous valid_o with no bubble.
- load_ready_o drops the cycle after hold fills. It rises the cycle after hold transfers into sreg.
- Reset asserted mid-word or with hold full: all contents are discarded immediately (asynchronous). Outputs take reset values without waiting for a clock edge. The first edge after deassertion sees IDLE.
- The load handshake is ignored while reset is high.

## Structure
- Package piso_pkg holds:
  - typedef enum logic {IDLE, SHIFT} piso_state_t
  - function cnt_w(DATA_W) returning $clog2(DATA_W)
- Sub-module piso_shift_stage holds sreg, cnt and the output muxing. The top level owns the FSM, the hold register and the handshakes.

## Test plan
- DATA_W=8, LSB_FIRST=1, load 0xA5 with serial_ready_i=1:
  - serial_o reads 1,0,1,0,0,1,0,1 over 8 consecutive valid cycles.
  - last_o is high only on the 8th cycle. empty_o=1 after.
- Load 0xA5, then 0x3C on the next cycle:
  - hold fills and load_ready_o drops.
  - 16 contiguous valid cycles, with 0x3C emitted as 0,0,1,1,1,1,0,0.
- LSB_FIRST=0, load 0xA5: serial_o reads 1,0,1,0,0,1,0,1 MSB-first.
- Drop serial_ready_i for 3 cycles after bit 2 of 0xF0: serial_o, last_o and cnt are frozen. The remaining bits resume in order.
- Raise load_valid_i on the same cycle as last_o with hold empty: the new word's bit 0 appears on the very next cycle.
- Assert reset on bit 4 of a word, with hold full: outputs return to reset values immediately. Both words are lost. empty_o=1 and load_ready_o=1.
